// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame snapshot,
// leading-zero suppression, per-digit blink, decimal points and dead time.
module seg_scan_driver #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64,
    parameter bit HEX       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [FRM_W-1:0]    frame_cnt;
    logic                phase;

    logic [4*DIGITS-1:0] digits_snap;
    logic [DIGITS-1:0]   dp_snap;
    logic [DIGITS-1:0]   blink_snap;
    logic                lz_snap;
    logic                phase_snap;

    logic                frame_start;
    logic [3:0]          nib;
    logic                lz_hit;
    logic                blink_hit;
    logic [DIGITS-1:0]   an_next;
    logic [7:0]          seg_next;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001101;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = HEX ? 7'b0001000 : 7'b1111111;
            4'hB:    glyph = HEX ? 7'b1100000 : 7'b1111111;
            4'hC:    glyph = HEX ? 7'b0110001 : 7'b1111111;
            4'hD:    glyph = HEX ? 7'b1000010 : 7'b1111111;
            4'hE:    glyph = HEX ? 7'b0110000 : 7'b1111111;
            default: glyph = HEX ? 7'b0111000 : 7'b1111111;
        endcase
    endfunction

    assign frame_start = (cnt == '0) && (idx == '0);
    assign nib         = digits_snap[{idx, 2'b00} +: 4];
    assign blink_hit   = phase_snap && blink_snap[idx];

    // Slot k is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lz_hit = lz_snap && (idx != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= int'(idx) && digits_snap[4*k +: 4] != 4'h0)
                lz_hit = 1'b0;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        an_next  = '1;
        seg_next = 8'hFF;
        if (cnt != '0 && !blink_hit) begin
            if (!lz_hit) begin
                an_next  = ~(DIGITS'(1) << idx);
                seg_next = {glyph(nib), ~dp_snap[idx]};
            end else if (dp_snap[idx]) begin
                an_next  = ~(DIGITS'(1) << idx);
                seg_next = 8'hFE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            phase       <= 1'b0;
            digits_snap <= '0;
            dp_snap     <= '0;
            blink_snap  <= '0;
            lz_snap     <= 1'b0;
            phase_snap  <= 1'b0;
            an          <= '1;
            seg         <= 8'hFF;
            frame_tick  <= 1'b0;
        end else if (!enable) begin
            // NOTE: non-blocking for all state so every register samples pre-edge values.
            cnt        <= '0;
            idx        <= '0;
            an         <= '1;
            seg        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            frame_tick <= frame_start;

            // The blink phase joins the snapshot, so a toggle shows from the following frame.
            if (frame_start) begin
                digits_snap <= digits_in;
                dp_snap     <= dp_in;
                blink_snap  <= blink_mask;
                lz_snap     <= blank_lz;
                phase_snap  <= phase;
                if (frame_cnt == FRM_W'(BLINK_DIV - 1)) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            if (cnt == CNT_W'(SCAN_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a decimal and a hex instance share stimulus,
// every cycle compares {frame_tick, an, seg} against hand-derived values.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        blank_lz;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic [3:0]  an_d, an_h;
    logic [7:0]  seg_d, seg_h;
    logic        ft_d, ft_h;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .HEX(1'b0)) u_dec (
        .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .an(an_d), .seg(seg_d),
        .frame_tick(ft_d)
    );

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .HEX(1'b1)) u_hex (
        .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
        .blink_mask(blink_mask), .blank_lz(blank_lz), .an(an_h), .seg(seg_h),
        .frame_tick(ft_h)
    );

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed ft/an/seg=%b required %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic ft, input logic [3:0] an_e,
                       input logic [7:0] seg_e, input logic [7:0] seg_h_e);
        check({tag, ".dec"}, {ft_d, an_d, seg_d}, {ft, an_e, seg_e});
        check({tag, ".hex"}, {ft_h, an_h, seg_h}, {ft, an_e, seg_h_e});
    endtask

    task automatic chk(input string tag, input logic ft, input logic [3:0] an_e,
                       input logic [7:0] seg_e, input logic [7:0] seg_h_e);
        tick();
        cmp(tag, ft, an_e, seg_e, seg_h_e);
    endtask

    // One slot: dead cycle (frame_tick only in slot 0), then three lit cycles.
    task automatic slot_hex(input string tag, input int k, input logic [3:0] an_e,
                            input logic [7:0] seg_e, input logic [7:0] seg_h_e);
        string t;
        t = $sformatf("%s.s%0d", tag, k);
        chk({t, ".dead"}, (k == 0), 4'hF, 8'hFF, 8'hFF);
        repeat (3) chk({t, ".lit"}, 1'b0, an_e, seg_e, seg_h_e);
    endtask

    task automatic slot(input string tag, input int k, input logic [3:0] an_e,
                        input logic [7:0] seg_e);
        slot_hex(tag, k, an_e, seg_e, seg_e);
    endtask

    initial begin
        bit    vis;
        string t;

        rst = 1'b1; enable = 1'b0; blank_lz = 1'b0;
        digits_in = 16'h1234; dp_in = 4'b0000; blink_mask = 4'b0000;
        #1;
        cmp("reset", 1'b0, 4'hF, 8'hFF, 8'hFF);
        tick(); tick();
        enable = 1'b1;
        rst    = 1'b0;

        // Plain scan of 1234
        slot("scan", 0, 4'b1110, 8'b10011001);
        slot("scan", 1, 4'b1101, 8'b00001101);
        slot("scan", 2, 4'b1011, 8'b00100101);
        slot("scan", 3, 4'b0111, 8'b10011111);

        // Reset asserted while digit 2 is lit
        slot("pre_rst", 0, 4'b1110, 8'b10011001);
        slot("pre_rst", 1, 4'b1101, 8'b00001101);
        chk("pre_rst.s2.dead", 1'b0, 4'hF, 8'hFF, 8'hFF);
        chk("pre_rst.s2.lit", 1'b0, 4'b1011, 8'b00100101, 8'b00100101);
        #2;
        rst = 1'b1;
        #1;
        cmp("rst_async", 1'b0, 4'hF, 8'hFF, 8'hFF);
        tick();
        cmp("rst_held", 1'b0, 4'hF, 8'hFF, 8'hFF);
        blank_lz  = 1'b1;
        digits_in = 16'h0070;
        rst       = 1'b0;

        // Leading-zero suppression on 0070
        slot("lz70", 0, 4'b1110, 8'b00000011);
        digits_in = 16'h0000;
        slot("lz70", 1, 4'b1101, 8'b00011011);
        slot("lz70", 2, 4'hF, 8'hFF);
        slot("lz70", 3, 4'hF, 8'hFF);

        // All zero: only digit 0 shows
        slot("lz00", 0, 4'b1110, 8'b00000011);
        dp_in = 4'b0100;
        slot("lz00", 1, 4'hF, 8'hFF);
        slot("lz00", 2, 4'hF, 8'hFF);
        slot("lz00", 3, 4'hF, 8'hFF);

        // Suppressed digit with lit dp still drives its anode
        slot("lzdp", 0, 4'b1110, 8'b00000011);
        blank_lz  = 1'b0;
        dp_in     = 4'b0000;
        digits_in = 16'h1234;
        slot("lzdp", 1, 4'hF, 8'hFF);
        slot("lzdp", 2, 4'b1011, 8'b11111110);
        slot("lzdp", 3, 4'hF, 8'hFF);

        // Mid-frame input change is held off until the next frame
        slot("snap", 0, 4'b1110, 8'b10011001);
        digits_in = 16'h5678;
        slot("snap", 1, 4'b1101, 8'b00001101);
        slot("snap", 2, 4'b1011, 8'b00100101);
        slot("snap", 3, 4'b0111, 8'b10011111);
        slot("snap_next", 0, 4'b1110, 8'b00000001);
        slot("snap_next", 1, 4'b1101, 8'b00011011);
        slot("snap_next", 2, 4'b1011, 8'b01000001);
        slot("snap_next", 3, 4'b0111, 8'b01001001);

        // Blink on digit 0, dp on digit 1, frames counted from reset
        rst = 1'b1;
        tick();
        digits_in  = 16'h1234;
        blink_mask = 4'b0001;
        dp_in      = 4'b0010;
        rst        = 1'b0;
        for (int f = 0; f < 5; f++) begin
            vis = ((f / 2) % 2) == 0;
            t   = $sformatf("blink.f%0d", f);
            slot(t, 0, vis ? 4'b1110 : 4'b1111, vis ? 8'b10011001 : 8'hFF);
            slot(t, 1, 4'b1101, 8'b00001100);
            slot(t, 2, 4'b1011, 8'b00100101);
            slot(t, 3, 4'b0111, 8'b10011111);
        end

        // Frame 5 (phase 0), interrupted by enable low mid-slot
        slot("blink.f5", 0, 4'b1110, 8'b10011001);
        slot("blink.f5", 1, 4'b1101, 8'b00001100);
        chk("blink.f5.s2.dead", 1'b0, 4'hF, 8'hFF, 8'hFF);
        chk("blink.f5.s2.lit", 1'b0, 4'b1011, 8'b00100101, 8'b00100101);
        enable = 1'b0;
        repeat (3) chk("disabled", 1'b0, 4'hF, 8'hFF, 8'hFF);
        enable = 1'b1;

        // Re-enable starts a fresh frame; blink resumes in phase 1
        slot("blink.f6", 0, 4'hF, 8'hFF);
        slot("blink.f6", 1, 4'b1101, 8'b00001100);
        slot("blink.f6", 2, 4'b1011, 8'b00100101);
        slot("blink.f6", 3, 4'b0111, 8'b10011111);

        // Hex glyphs versus decimal blanking on ABCF
        rst = 1'b1;
        tick();
        digits_in  = 16'hABCF;
        blink_mask = 4'b0000;
        dp_in      = 4'b0000;
        rst        = 1'b0;
        slot_hex("hex", 0, 4'b1110, 8'hFF, 8'b01110001);
        slot_hex("hex", 1, 4'b1101, 8'hFF, 8'b01100011);
        slot_hex("hex", 2, 4'b1011, 8'hFF, 8'b11000001);
        slot_hex("hex", 3, 4'b0111, 8'hFF, 8'b00010001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a common-anode multi-digit 7-segment display. It scans `DIGITS` BCD/hex nibbles onto one shared active-low segment bus with per-digit anode strobes. Features: frame-coherent input snapshot, leading-zero suppression, per-digit blink, decimal points and anti-ghosting dead time. It sits between the alarm-clock time/alarm datapath and the board display pins.

## Interface
- `DIGITS`, 4: number of digits, legal 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot, legal ≥2.
- `BLINK_DIV`, 64: frames per blink half-period, legal ≥1.
- `HEX`, 0: 0 = decimal glyphs (codes 10–15 blank); 1 = hex glyphs A–F.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `enable` in 1: 1 = scanning; 0 = display dark.
- `digits_in` in 4*DIGITS: nibble k = digit k; digit 0 is rightmost.
- `dp_in` in DIGITS: 1 = decimal point lit on digit k.
- `blink_mask` in DIGITS: 1 = digit k blinks.
- `blank_lz` in 1: 1 = suppress leading zeros.
- `an` out DIGITS: anode strobes, active-low, at most one bit 0.
- `seg` out 8: {a,b,c,d,e,f,g,dp}, active-low (0 = lit).
- `frame_tick` out 1: one-cycle pulse at start of each frame.

## Operation
- Glyphs (seg[7:1], before dp):
  - 0 `0000001`, 1 `1001111`, 2 `0010010`, 3 `0000110`, 4 `1001100`.
  - 5 `0100100`, 6 `0100000`, 7 `0001101`, 8 `0000000`, 9 `0000100`.
  - HEX=1: A `0001000`, b `1100000`, C `0110001`, d `1000010`, E `0110000`, F `0111000`.
  - HEX=0: codes 10–15 → `1111111`.
- seg[0] = ~dp_snapshot[k] whenever slot k is not blanked.
- Internal counters: `cnt` runs 0..SCAN_DIV-1 and `idx` runs 0..DIGITS-1, with `idx` advancing when `cnt` wraps. Frame = DIGITS slots.
- Frame-start edge E0 is any enabled edge with cnt=0, idx=0. At E0:
  - Capture `digits_in`, `dp_in`, `blink_mask` and `blank_lz` into a snapshot. All glyph decisions for the frame use the snapshot only.
  - Increment `frame_cnt`. When it is at BLINK_DIV-1, wrap it to 0 and toggle `phase`.
- Registered outputs, decided from the counter values before each edge:
  - cnt=0 (dead cycle): an = all 1, seg = 8'hFF.
  - cnt≠0, slot k not blanked: an = ~(1<<k), seg = glyph of k with dp applied.
  - cnt≠0, slot k blanked: an = all 1, seg = 8'hFF.
- Slot k is blanked when either holds:
  - phase=1 and blink_mask_snap[k]=1 (digit and dp both dark).
  - blank_lz_snap=1, k≠0, and nibbles k..DIGITS-1 are all zero (glyph blanked; the lit dp still drives that anode).
- Digit 0 is never LZ-suppressed.
- `enable`=0 at an edge: an = all 1, seg = FF, frame_tick = 0, cnt/idx ← 0. frame_cnt, phase and snapshot hold. The next enabled edge is an E0.

## Timing
- Reset (async, immediate):
  - Outputs: an = all 1, seg = 8'hFF, frame_tick = 0.
  - State: cnt, idx, frame_cnt and phase = 0; snapshot cleared.
- Reset asserted mid-frame aborts the frame with no partial glyph held. The first enabled edge after release is E0.
- Relative to E0: output cycle E0→E0+1 is dead for digit 0. Digit 0 is shown for the next SCAN_DIV-1 cycles. The dead cycle of digit 1 follows at E0+SCAN_DIV.
- `frame_tick` is high for exactly the cycle after E0. Its period is DIGITS*SCAN_DIV cycles while enabled.
- Input changes reach the display only at the next E0; latency to visible is 1 cycle after that E0 + dead cycle.
- Blink: frames numbered from 0 after reset show phase 0 for frames 0..BLINK_DIV-1, phase 1 for the next BLINK_DIV, and so on. A phase change takes effect from the slot 0 content of that frame.
- Enable toggling does not reset blink phase; the phase resumes where it stopped.

## Test plan
- Params DIGITS=4, SCAN_DIV=4, BLINK_DIV=2, HEX=0 unless stated.
- Reset: assert rst mid-frame with digit 2 lit → an=4'b1111, seg=8'hFF, frame_tick=0 before the next clk edge. Release → frame_tick pulses 1 cycle after first edge, then every 16 cycles.
- Scan: digits_in=16'h1234, dp_in=0 → per slot 1 dead cycle (1111/FF) followed by:
  - an=1110 seg=10011001 ×3.
  - an=1101 seg=00001101 ×3.
  - an=1011 seg=00100101 ×3.
  - an=0111 seg=10011111 ×3.
- LZ: blank_lz=1, digits_in=16'h0070 → slots 3,2 dark; slot1 seg=00011011; slot0 seg=00000011. With digits_in=0, only slot0 shows 00000011. dp_in=4'b0100 with digits_in=0 → slot2 an=1011 seg=11111110.
- Snapshot: change digits_in 16'h1234→16'h5678 during slot 1 → rest of frame still shows 3,2,1. Next frame slot0 seg=00000001.
- Blink/dp: blink_mask=0001, dp_in=0010 → slot0 visible in frames 0,1, dark (1111/FF) in frames 2,3, visible again in 4. slot1 seg[0]=0 in every frame.
- HEX: HEX=1, digits_in=16'hABCF → slot0 F=01110001, slot1 C=01100011, slot2 b=11000001, slot3 A=00010001. HEX=0 with the same input → all four slots seg=8'hFF.
